// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, segment patterns and decode helper for signed_bcd_display
package display_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_e;

    // Active-high {g,f,e,d,c,b,a} patterns for the digits 0-9.
    localparam seg_t SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam seg_t SEG_BLANK = 7'h00;

    // Non-decimal nibbles decode to blank; active_low inverts the pattern.
    function automatic seg_t seg_decode(input bcd_t v, input bit active_low);
        seg_t s;
        s = SEG_BLANK;
        if (v <= 4'd9) begin
            s = SEG_DIGIT[int'(v)];
        end
        return active_low ? ~s : s;
    endfunction

    // Decimal digits needed to show 2^(w-1), the largest magnitude of a w-bit signed value.
    function automatic int bcd_digits_needed(input int w);
        longint unsigned v;
        int n;
        v = 64'd1 << (w - 1);
        n = 1;
        v = v / 10;
        while (v != 0) begin
            n = n + 1;
            v = v / 10;
        end
        return n;
    endfunction

endpackage

// File: rtl/signed_bcd_display_bin_to_bcd_seq.sv
// rtl/signed_bcd_display_bin_to_bcd_seq.sv - iterative double-dabble binary to BCD converter
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load mag and begin a DATA_W-cycle conversion (ignored results in flight are discarded)
//   mag       : unsigned magnitude to convert
//   done      : high during the final iteration cycle; bcd is valid on the following cycle
//   bcd       : DIGITS packed BCD nibbles, nibble 0 = least significant digit
module bin_to_bcd_seq #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     mag,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] r_mag;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [BCD_W-1:0]  w_bcd_adj;
    logic              w_last;

    // Add-3 correction on every nibble >= 5 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_last = r_busy && (r_cnt == CNT_W'(DATA_W - 1));
    assign done   = w_last;
    assign bcd    = r_bcd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_mag  <= mag;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd <= {w_bcd_adj[BCD_W-2:0], r_mag[DATA_W-1]};
            r_mag <= {r_mag[DATA_W-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/signed_bcd_display.sv
// rtl/signed_bcd_display.sv - signed result to multiplexed seven-segment display engine
//
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the most significant nonzero one).
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : handshake for in_data; ready only while idle
//   in_data         : signed two's-complement result
//   conv_done       : one-cycle pulse when a new value reaches the display register
//   sign            : displayed value is negative
//   segments        : {g,f,e,d,c,b,a} for the selected digit, polarity set by SEG_ACTIVE_LOW
//   display_select  : one-hot active-high digit enable, bit 0 = least significant digit
module signed_bcd_display
    import display_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int DIGITS         = 5,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              conv_done,
    output logic              sign,
    output logic [6:0]        segments,
    output logic [DIGITS-1:0] display_select
);

    localparam int   BCD_W   = 4 * DIGITS;
    localparam int   RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int   IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam bit   ACT_LOW = (SEG_ACTIVE_LOW != 0);
    localparam seg_t SEG_OFF = ACT_LOW ? ~SEG_BLANK : SEG_BLANK;

    if (bcd_digits_needed(DATA_W) > DIGITS) begin : g_digits_too_few
        $error("signed_bcd_display: DIGITS too small for DATA_W");
    end

    state_e             r_state;
    state_e             w_next_state;
    logic               w_start;
    logic               w_commit;
    logic               w_accept;
    logic [DATA_W-1:0]  w_mag;
    logic               w_bcd_done;
    logic [BCD_W-1:0]   w_bcd;
    logic [DIGITS-1:0]  w_blank_mask;

    logic               r_in_ready;
    logic               r_conv_done;
    logic               r_pend_sign;
    logic               r_sign;
    logic [BCD_W-1:0]   r_disp_bcd;
    logic [DIGITS-1:0]  r_disp_blank;

    logic [RW-1:0]      r_refresh_cnt;
    logic [IW-1:0]      r_digit_idx;
    logic [DIGITS-1:0]  r_sel;
    seg_t               r_seg;
    bcd_t               w_nib;
    logic               w_nib_blank;
    seg_t               w_seg;

    assign w_accept = in_valid && r_in_ready;
    // Two's-complement negate; -2^(DATA_W-1) maps onto itself, which reads correctly as unsigned.
    assign w_mag    = in_data[DATA_W-1] ? (~in_data + 1'b1) : in_data;

    bin_to_bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin_to_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .mag   (w_mag),
        .done  (w_bcd_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_start      = 1'b1;
                    w_next_state = CONV;
                end
            end
            CONV: begin
                if (w_bcd_done) begin
                    w_next_state = COMMIT;
                end
            end
            COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic v_all_zero;
        v_all_zero   = 1'b1;
        w_blank_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_all_zero      = v_all_zero && (w_bcd[4*i +: 4] == 4'd0);
            w_blank_mask[i] = v_all_zero;
        end
    end
`else
    assign w_blank_mask = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready   <= 1'b0;
            r_conv_done  <= 1'b0;
            r_pend_sign  <= 1'b0;
            r_sign       <= 1'b0;
            r_disp_bcd   <= '0;
            r_disp_blank <= '0;
        end else begin
            r_in_ready  <= (w_next_state == IDLE);
            r_conv_done <= w_commit;
            if (w_start) begin
                r_pend_sign <= in_data[DATA_W-1];
            end
            if (w_commit) begin
                r_sign       <= r_pend_sign;
                r_disp_bcd   <= w_bcd;
                r_disp_blank <= w_blank_mask;
            end
        end
    end

    always_comb begin
        w_nib       = '0;
        w_nib_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit_idx == IW'(i)) begin
                w_nib       = r_disp_bcd[4*i +: 4];
                w_nib_blank = r_disp_blank[i];
            end
        end
        w_seg = w_nib_blank ? SEG_OFF : seg_decode(w_nib, ACT_LOW);
    end

    // Free-running refresh; select and segments register together so they never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= '0;
            r_sel         <= '0;
            r_seg         <= SEG_OFF;
        end else begin
            if (r_refresh_cnt == RW'(REFRESH_DIV - 1)) begin
                r_refresh_cnt <= '0;
                r_digit_idx   <= (r_digit_idx == IW'(DIGITS - 1)) ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
            r_sel <= DIGITS'(1) << r_digit_idx;
            r_seg <= w_seg;
        end
    end

    assign in_ready       = r_in_ready;
    assign conv_done      = r_conv_done;
    assign sign           = r_sign;
    assign segments       = r_seg;
    assign display_select = r_sel;

endmodule

// File: tb/tb_signed_bcd_display.sv
// tb/tb_signed_bcd_display.sv - directed self-checking bench for signed_bcd_display
module tb_signed_bcd_display;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        conv_done;
    logic        sign;
    logic [6:0]  segments;
    logic [4:0]  display_select;

    int checks;
    int failures;

    // Active-low patterns for 0-9.
    logic [6:0] seg_lo [0:9];

    signed_bcd_display #(
        .DATA_W         (16),
        .DIGITS         (5),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .conv_done      (conv_done),
        .sign           (sign),
        .segments       (segments),
        .display_select (display_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d, input int absval);
        int p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && absval < p) return 7'h7F;
`endif
        return seg_lo[(absval / p) % 10];
    endfunction

    // Called at a negedge; returns at the negedge where conv_done is seen.
    task automatic send(input logic [15:0] v, input string tag);
        int  lat;
        bit  seen;
        in_data  = v;
        in_valid = 1'b1;
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (conv_done) seen = 1;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd17);
    endtask

    task automatic check_value(input logic [15:0] v, input string tag);
        int  sv;
        int  absval;
        bit  found;
        sv     = int'($signed(v));
        absval = (sv < 0) ? -sv : sv;
        check_eq({tag, "_sign"}, 32'(sign), 32'(sv < 0));
        @(posedge clk);
        for (int d = 4; d >= 0; d--) begin
            found = 0;
            for (int k = 0; k < 30 && !found; k++) begin
                @(negedge clk);
                if (display_select == (5'd1 << d)) found = 1;
            end
            check_eq($sformatf("%s_sel%0d_found", tag, d), 32'(found), 32'd1);
            check_eq($sformatf("%s_dig%0d", tag, d), 32'(segments), 32'(exp_seg(d, absval)));
        end
    endtask

    initial begin
        int  pulses;
        seg_lo[0] = 7'h40; seg_lo[1] = 7'h79; seg_lo[2] = 7'h24; seg_lo[3] = 7'h30;
        seg_lo[4] = 7'h19; seg_lo[5] = 7'h12; seg_lo[6] = 7'h02; seg_lo[7] = 7'h78;
        seg_lo[8] = 7'h00; seg_lo[9] = 7'h10;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_done", 32'(conv_done), 32'd0);
        check_eq("rst_sign", 32'(sign), 32'd0);
        check_eq("rst_sel", 32'(display_select), 32'd0);
        check_eq("rst_seg", 32'(segments), 32'h7F);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_ready", 32'(in_ready), 32'd1);
        check_eq("rel_sel", 32'(display_select), 32'd1);
        check_eq("rel_seg", 32'(segments), 32'h40);

        send(-16'sd1234, "neg1234");
        check_value(-16'sd1234, "neg1234");
        @(negedge clk);
        send(16'h8000, "min");
        check_value(16'h8000, "min");
        @(negedge clk);
        send(16'h7FFF, "max");
        check_value(16'h7FFF, "max");
        @(negedge clk);
        send(16'd0, "zero");
        check_value(16'd0, "zero");
        @(negedge clk);
        send(16'd42, "v42");
        check_value(16'd42, "v42");

        // Second request during conversion must be dropped.
        @(negedge clk);
        in_data  = 16'd100;
        in_valid = 1'b1;
        check_eq("ign_ready0", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("ign_busy", 32'(in_ready), 32'd0);
        in_data  = 16'd999;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40 && pulses == 0; k++) begin
            @(negedge clk);
            if (conv_done) pulses++;
        end
        check_eq("ign_first_done", 32'(pulses), 32'd1);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (conv_done) pulses++;
        end
        check_eq("ign_no_second", 32'(pulses), 32'd0);
        check_value(16'd100, "ign");

        // Back-to-back: second accept in the cycle right after commit.
        @(negedge clk);
        send(16'd7, "b2b_a");
        send(-16'sd5, "b2b_b");
        check_value(-16'sd5, "b2b_b");

        // Reset five cycles into a conversion.
        @(negedge clk);
        in_data  = 16'd1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_sign", 32'(sign), 32'd0);
        check_eq("mid_rst_sel", 32'(display_select), 32'd0);
        check_eq("mid_rst_seg", 32'(segments), 32'h7F);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (conv_done) pulses++;
            check_eq($sformatf("run_sel_%0d", k), 32'(display_select), 32'(5'd1 << (((k - 1) / 4) % 5)));
            check_eq($sformatf("run_seg_%0d", k), 32'(segments), 32'(exp_seg(((k - 1) / 4) % 5, 0)));
        end
        check_eq("mid_rst_no_done", 32'(pulses), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
